// File: rtl/uart_fifo_stat.sv
// uart_fifo_stat: byte FIFO for the wb_uart TX/RX paths with occupancy level,
// programmable almost-full/almost-empty thresholds and sticky error flags.
// All 2**ADDRESS_WIDTH entries are usable; full is tracked through the level
// counter rather than by sacrificing a slot.
module uart_fifo_stat #(
  parameter int unsigned ADDRESS_WIDTH      = 4,
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned ALMOST_FULL_LEVEL  = (2 ** ADDRESS_WIDTH) - 2,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     write_enable,
  input  logic [DATA_WIDTH-1:0]    data_a,
  output logic                     write_ack,
  input  logic                     read_enable,
  output logic                     read_ack,
  output logic [DATA_WIDTH-1:0]    data_b,
  input  logic                     fifo_flush,
  output logic                     empty,
  output logic                     full,
  output logic [ADDRESS_WIDTH:0]   level,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int unsigned LW    = ADDRESS_WIDTH + 1;

  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_AF   = LW'(ALMOST_FULL_LEVEL);
  localparam logic [LW-1:0] LEVEL_AE   = LW'(ALMOST_EMPTY_LEVEL);

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [LW-1:0]            level_q;
  logic [LW-1:0]            level_d;
  logic                     wr_accept;
  logic                     rd_accept;

  // Status flags derive only from the registered level, never from inputs.
  assign level        = level_q;
  assign empty        = (level_q == '0);
  assign full         = (level_q == LEVEL_FULL);
  assign almost_full  = (level_q >= LEVEL_AF);
  assign almost_empty = (level_q <= LEVEL_AE);

  // Acceptance is judged on pre-edge full/empty; flush drops both requests.
  assign wr_accept = write_enable & ~full  & ~fifo_flush;
  assign rd_accept = read_enable  & ~empty & ~fifo_flush;

  // Next occupancy: a simultaneous accepted write and read cancel out.
  always_comb begin
    level_d = level_q;
    if (fifo_flush) begin
      level_d = '0;
    end else begin
      unique case ({wr_accept, rd_accept})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= data_a;
    end
  end

  // Read/write pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (fifo_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + ADDRESS_WIDTH'(1);
      if (rd_accept) rd_ptr <= rd_ptr + ADDRESS_WIDTH'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  // Ack pulses and registered read data; data_b holds between reads and on flush.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      write_ack <= 1'b0;
      read_ack  <= 1'b0;
      data_b    <= '0;
    end else begin
      write_ack <= wr_accept;
      read_ack  <= rd_accept;
      if (rd_accept) begin
        data_b <= mem[rd_ptr];
      end
    end
  end

  // Sticky error flags, cleared only by reset or flush.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (fifo_flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_enable && full)  overflow  <= 1'b1;
      if (read_enable  && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_fifo_stat.sv
// Self-checking bench for uart_fifo_stat (depth 4, thresholds 3/1): directed
// scenarios plus randomized traffic against a queue-based reference model.
module tb_uart_fifo_stat;

  localparam int unsigned AW    = 2;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          resetn;
  logic          write_enable;
  logic [DW-1:0] data_a;
  logic          write_ack;
  logic          read_enable;
  logic          read_ack;
  logic [DW-1:0] data_b;
  logic          fifo_flush;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic          m_ovf, m_unf, m_wack, m_rack;
  logic [DW-1:0] m_data;

  uart_fifo_stat #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
    .ALMOST_FULL_LEVEL(3), .ALMOST_EMPTY_LEVEL(1)
  ) dut (
    .clk(clk), .resetn(resetn),
    .write_enable(write_enable), .data_a(data_a), .write_ack(write_ack),
    .read_enable(read_enable), .read_ack(read_ack), .data_b(data_b),
    .fifo_flush(fifo_flush), .empty(empty), .full(full), .level(level),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_unf = 0; m_wack = 0; m_rack = 0; m_data = '0;
  endtask

  // One clock: drive at negedge, update model from pre-edge state, settle.
  task automatic step(input logic we, input logic [DW-1:0] d, input logic re, input logic fl);
    bit can_w, can_r;
    @(negedge clk);
    write_enable = we; data_a = d; read_enable = re; fifo_flush = fl;
    @(posedge clk);
    if (fl) begin
      q.delete(); m_ovf = 0; m_unf = 0; m_wack = 0; m_rack = 0;
    end else begin
      can_w = we && (q.size() < DEPTH);
      can_r = re && (q.size() > 0);
      if (we && !can_w) m_ovf = 1;
      if (re && !can_r) m_unf = 1;
      if (can_r) m_data = q.pop_front();
      if (can_w) q.push_back(d);
      m_wack = can_w; m_rack = can_r;
    end
    #1;
    write_enable = 0; read_enable = 0; fifo_flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1; #2; resetn = 0;
    model_reset();
  endtask

  task automatic test_reset();
    resetn = 1; write_enable = 0; read_enable = 0; fifo_flush = 0; data_a = '0;
    #12; model_reset();
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin bad++; $display("FAIL reset_status got=%b want=1010", {empty, full, almost_empty, almost_full}); end
    total++; if ({write_ack, read_ack, overflow, underflow} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {write_ack, read_ack, overflow, underflow}); end
    total++; if (data_b !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data_b); end
    @(negedge clk); resetn = 0;
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step(1, vals[i], 0, 0);
      total++; if (write_ack !== 1'b1) begin bad++; $display("FAIL fill_wack[%0d] got=%b want=1", i, write_ack); end
    end
    total++; if (level !== 3'd4 || full !== 1'b1 || almost_full !== 1'b1) begin bad++; $display("FAIL fill_status got=lvl%0d f%b af%b want=lvl4 f1 af1", level, full, almost_full); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0);
      total++; if (read_ack !== 1'b1 || data_b !== vals[i]) begin bad++; $display("FAIL drain[%0d] got=ack%b %h want=ack1 %h", i, read_ack, data_b, vals[i]); end
    end
    total++; if (empty !== 1'b1 || level !== 3'd0) begin bad++; $display("FAIL drain_empty got=e%b lvl%0d want=e1 lvl0", empty, level); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) step(1, DW'(i * 17), 0, 0);
    step(1, 8'h55, 0, 0);
    total++; if (write_ack !== 1'b0 || overflow !== 1'b1 || level !== 3'd4) begin bad++; $display("FAIL ovf_reject got=wack%b ovf%b lvl%0d want=wack0 ovf1 lvl4", write_ack, overflow, level); end
    step(0, 0, 1, 0);
    total++; if (data_b !== 8'h11) begin bad++; $display("FAIL ovf_first_read got=%h want=11", data_b); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      total++; if (data_b === 8'h55 || data_b !== m_data) begin bad++; $display("FAIL ovf_drain[%0d] got=%h want=%h", i, data_b, m_data); end
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_underflow();
    logic [DW-1:0] prev;
    prev = data_b;
    step(0, 0, 1, 0);
    total++; if (read_ack !== 1'b0 || data_b !== prev || underflow !== 1'b1) begin bad++; $display("FAIL unf_reject got=ack%b %h unf%b want=ack0 %h unf1", read_ack, data_b, underflow, prev); end
    step(1, 8'hA5, 1, 0);
    total++; if (level !== 3'd1 || underflow !== 1'b1 || read_ack !== 1'b0 || data_b !== prev) begin bad++; $display("FAIL unf_simul got=lvl%0d unf%b ack%b %h want=lvl1 unf1 ack0 %h", level, underflow, read_ack, data_b, prev); end
    step(0, 0, 1, 0);
    total++; if (data_b !== 8'hA5 || read_ack !== 1'b1) begin bad++; $display("FAIL unf_next_read got=%h ack%b want=a5 ack1", data_b, read_ack); end
    step(0, 0, 0, 1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      step(1, DW'(i), 0, 0);
      total++; if (level !== 3'd1) begin bad++; $display("FAIL wrap_lvl1[%0d] got=%0d want=1", i, level); end
      step(0, 0, 1, 0);
      total++; if (data_b !== DW'(i) || level !== 3'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL wrap_read[%0d] got=%h lvl%0d ovf%b unf%b want=%h lvl0 00", i, data_b, level, overflow, underflow, DW'(i)); end
    end
  endtask

  task automatic test_simult();
    bit [3:0] exp_thr [5] = '{4'b01, 4'b01, 4'b00, 4'b10, 4'b10};
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h03, 1, 0);
    total++; if (level !== 3'd2 || data_b !== 8'h01) begin bad++; $display("FAIL simul_lvl2 got=lvl%0d %h want=lvl2 01", level, data_b); end
    step(1, 8'h04, 0, 0);
    step(1, 8'h05, 0, 0);
    step(1, 8'h66, 1, 0);
    total++; if (read_ack !== 1'b1 || write_ack !== 1'b0 || overflow !== 1'b1 || level !== 3'd3 || data_b !== 8'h02) begin bad++; $display("FAIL simul_full got=rack%b wack%b ovf%b lvl%0d %h want=1 0 1 lvl3 02", read_ack, write_ack, overflow, level, data_b); end
    step(0, 0, 0, 1);
    for (int l = 0; l <= 4; l++) begin
      total++; if ({almost_full, almost_empty} !== exp_thr[l][1:0]) begin bad++; $display("FAIL thresh[lvl%0d] got=af%b ae%b want=%b", l, almost_full, almost_empty, exp_thr[l][1:0]); end
      if (l < 4) step(1, DW'(l), 0, 0);
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) step(1, DW'(8'h70 + i), 0, 0);
    step(1, 8'h7F, 0, 0);
    step(0, 0, 1, 0);
    total++; if (level !== 3'd3 || overflow !== 1'b1) begin bad++; $display("FAIL flush_pre got=lvl%0d ovf%b want=lvl3 ovf1", level, overflow); end
    step(1, 8'h99, 0, 1);
    total++; if (level !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || write_ack !== 1'b0 || data_b !== 8'h70) begin bad++; $display("FAIL flush got=lvl%0d e%b ovf%b wack%b %h want=lvl0 e1 ovf0 wack0 70", level, empty, overflow, write_ack, data_b); end
  endtask

  task automatic test_async_reset();
    step(1, 8'h3C, 0, 0);
    step(1, 8'h3D, 1, 0);
    #2 resetn = 1;
    #1;
    model_reset();
    total++; if ({write_ack, read_ack, overflow, underflow, empty, full} !== 6'b000010 || level !== 3'd0 || data_b !== 8'h00) begin bad++; $display("FAIL async_reset got=%b lvl%0d %h want=000010 lvl0 00", {write_ack, read_ack, overflow, underflow, empty, full}, level, data_b); end
    @(negedge clk); resetn = 0;
    step(0, 0, 0, 0);
    total++; if (write_ack !== 1'b0 || read_ack !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL post_reset_ack got=wack%b rack%b lvl%0d want=0 0 0", write_ack, read_ack, level); end
  endtask

  task automatic test_random();
    int wp, rp;
    for (int n = 0; n < 400; n++) begin
      wp = (n / 50) % 2 == 0 ? 70 : 30;
      rp = 100 - wp;
      step(($urandom_range(99) < wp), DW'($urandom), ($urandom_range(99) < rp), ($urandom_range(31) == 0));
      total++;
      if (level !== ($bits(level))'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
          almost_full !== (q.size() >= 3) || almost_empty !== (q.size() <= 1) ||
          overflow !== m_ovf || underflow !== m_unf || write_ack !== m_wack || read_ack !== m_rack || data_b !== m_data) begin
        bad++;
        $display("FAIL random[%0d] got=lvl%0d wack%b rack%b %h ovf%b unf%b want=lvl%0d wack%b rack%b %h ovf%b unf%b",
                 n, level, write_ack, read_ack, data_b, overflow, underflow, q.size(), m_wack, m_rack, m_data, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_wrap();
    test_simult();
    test_flush();
    test_async_reset();
    do_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_fifo_stat.md
Name: uart_fifo_stat

Overview:
- Parametrised successor to the UART byte FIFO, used in the wb_uart TX and RX paths between the Wishbone register file and the UART shifter.
- Adds:
  - true full detection with write rejection, so all 2**ADDRESS_WIDTH entries are usable;
  - an occupancy level output;
  - programmable almost-full and almost-empty thresholds for interrupt and flow control;
  - sticky overflow and underflow error flags.
- Single clock, synchronous RAM, registered read data.

Parameters:
- ADDRESS_WIDTH, 4, log2 of depth; DEPTH = 2**ADDRESS_WIDTH entries, all usable.
- DATA_WIDTH, 8, width of each entry.
- ALMOST_FULL_LEVEL, DEPTH-2, almost_full asserts when level >= this value. Legal range 1..DEPTH.
- ALMOST_EMPTY_LEVEL, 1, almost_empty asserts when level <= this value. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  reset, asynchronous and active-high (despite the name); asserting it clears all state immediately.
- write_enable  in  1  write request, sampled each clk edge.
- data_a  in  DATA_WIDTH  write data.
- write_ack  out  1  one-cycle pulse, one cycle after an accepted write.
- read_enable  in  1  read request, sampled each clk edge.
- read_ack  out  1  one-cycle pulse; data_b is valid in the same cycle.
- data_b  out  DATA_WIDTH  registered read data; holds its value between reads.
- fifo_flush  in  1  synchronous clear of the contents and error flags.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- level  out  ADDRESS_WIDTH+1  current occupancy, 0..DEPTH.
- almost_full  out  1  level >= ALMOST_FULL_LEVEL.
- almost_empty  out  1  level <= ALMOST_EMPTY_LEVEL.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (asynchronous, resetn=1):
  - Pointers = 0, level = 0, write_ack = 0, read_ack = 0, data_b = 0, overflow = 0, underflow = 0.
  - Therefore empty = 1, full = 0, almost_empty = 1, almost_full = 0 (given ALMOST_FULL_LEVEL >= 1).
  - RAM contents are not reset.
- Status outputs are combinational from registered state only. No input-to-output combinational path.
- Write accepted when write_enable=1, full=0 and fifo_flush=0 at an edge:
  - ram[wr_ptr] <= data_a; wr_ptr increments, wrapping modulo DEPTH.
  - write_ack = 1 for exactly the following cycle.
- Read accepted when read_enable=1, empty=0 and fifo_flush=0 at an edge:
  - data_b <= ram[rd_ptr]; rd_ptr increments, wrapping modulo DEPTH.
  - read_ack = 1 for exactly the following cycle. Read latency is 1 clk.
- Level update per edge: +1 on an accepted write only, -1 on an accepted read only, unchanged when both or neither are accepted. Level never exceeds DEPTH and never goes below 0.
- Full and empty are judged on pre-edge state:
  - Simultaneous write+read when full: read accepted, write rejected, overflow set, level becomes DEPTH-1.
  - Simultaneous write+read when empty: write accepted, read rejected, underflow set, read_ack = 0, data_b holds, level becomes 1.
  - Simultaneous write+read otherwise: both accepted, level unchanged.
- Rejected write (write_enable=1 and full=1): no RAM write, write_ack = 0, overflow <= 1.
- Rejected read (read_enable=1 and empty=1): read_ack = 0, data_b holds, underflow <= 1.
- Sticky flags clear only on reset or fifo_flush.
- fifo_flush has priority over write and read in the same cycle:
  - Pointers, level, overflow and underflow are cleared.
  - Any write or read requested in that cycle is dropped: no ack, no flag set.
  - data_b holds.
- Back-to-back operation: a write and/or read may be accepted every cycle. Sustained one write plus one read per cycle holds level constant.
- Data ordering is strict FIFO across pointer wrap-around.
- Reset asserted mid-operation aborts any pending ack. No ack pulse appears after reset deasserts without a new request.

Test Plan (ADDRESS_WIDTH=2, DATA_WIDTH=8, ALMOST_FULL_LEVEL=3, ALMOST_EMPTY_LEVEL=1):
- Fill and drain:
  - Write 0x11,0x22,0x33,0x44 on consecutive cycles -> write_ack pulses 4 times, level 4, full=1, almost_full=1.
  - Read 4 times -> data_b 0x11,0x22,0x33,0x44, each with read_ack, then empty=1.
- Overflow: with the FIFO full, write 0x55 -> write_ack=0, overflow=1, level stays 4. A subsequent read returns 0x11; 0x55 is never read.
- Underflow: with the FIFO empty, read -> read_ack=0, data_b unchanged, underflow=1. Simultaneous write 0xA5 + read on an empty FIFO -> level 1, underflow=1, next read returns 0xA5.
- Wrap-around: 10 rounds of write-then-read of values 0..9 -> each read returns the matching value, level toggles 1/0, no flags set.
- Simultaneous ops:
  - With level 2, write+read together -> level stays 2.
  - With the FIFO full, write 0x66 + read together -> read_ack=1, write rejected, overflow=1, level 3.
  - Thresholds: almost_empty=1 at level<=1, almost_full=1 at level>=3.
- Flush and reset:
  - With level 3 and overflow=1, assert fifo_flush together with write_enable -> next cycle level 0, empty=1, overflow=0, write_ack=0.
  - Assert resetn asynchronously mid-write -> all outputs return to reset values without waiting for a clk edge.
